imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single combinational instruction-memory read port between two requesters: the fetch stage (port F) and a debug/loader read port (port D).
- Per cycle, the block grants at most one request. It drives the memory address and returns the fetched word one cycle later through a registered response.
- Supports round-robin arbitration, debug burst locking, and alignment/range error reporting.
- Sits between the PC/fetch logic and the instruction memory.

Parameters:
- DEPTH, 129: number of 32-bit words in instruction memory; valid word index is 0..DEPTH-1.
- LOCK_MAX, 16: maximum consecutive D grants while dbg_lock is held before F is forced one grant.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request valid.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  fetch response valid (one-cycle pulse).
- f_rdata  out  32  fetch response word.
- f_err  out  1  fetch response error, valid with f_rvalid.
- d_req  in  1  debug request valid.
- d_addr  in  32  debug byte address.
- d_lock  in  1  debug requests a burst lock.
- d_gnt  out  1  debug request accepted this cycle (combinational).
- d_rvalid  out  1  debug response valid (one-cycle pulse).
- d_rdata  out  32  debug response word.
- d_err  out  1  debug response error, valid with d_rvalid.
- mem_address  out  32  byte address driven to instruction memory.
- mem_instruction  in  32  combinational read data from instruction memory.

Behaviour:
- Reset (synchronous, active-high): f_rvalid, d_rvalid, f_err, d_err are 0; f_rdata and d_rdata are 32'h0; last-grant pointer = D, so F wins the first tie; lock counter = 0; state = RR.
- Handshake:
  - A request transfers on the cycle where req=1 and gnt=1.
  - At most one gnt is high per cycle; gnt is never high without the matching req.
  - A requester holds req and addr stable until granted.
- mem_address:
  - Equals the granted requester's address.
  - Equals f_addr when nothing is granted, keeping the fetch path transparent.
- Latency: a grant in cycle N produces rvalid, rdata = mem_instruction sampled in cycle N, and err at cycle N+1 for the same port. Throughput is 1 grant per cycle. Responses have no backpressure.
- Error:
  - err = 1 if addr[1:0] != 0 or addr[31:2] >= DEPTH.
  - On error, rdata = 32'h0 (the NOP encoding) and rvalid is still asserted.
- State machine:
  - RR:
    - Only one req: grant it.
    - Both req: grant the port not granted last.
    - Go to LOCK when a D grant occurs with d_lock=1.
  - LOCK:
    - D has priority. Each D grant increments the lock counter.
    - When the counter reaches LOCK_MAX and f_req=1, grant F for one cycle, clear the counter, and stay in LOCK.
    - F is granted whenever d_req=0.
    - Exit to RR when d_lock=0 (evaluated each cycle); the counter clears.
  - The last-grant pointer updates on every grant in both states.
- Boundary conditions:
  - d_lock=1 without d_req: no state change from RR.
  - Reset asserted mid-burst: next state is RR. Any pending response is dropped, so the rvalid outputs are 0 the cycle after reset.
  - Simultaneous reset and req: no grant.
  - Address 32'hFFFFFFFC is out of range: err=1.
  - Word index DEPTH-1 is in range; DEPTH is out of range.

Optional Feature:
- Macro: IMEM_ARB_FIXED_PRIO_EN.
- Defined: the RR state uses fixed priority, with F always winning ties. LOCK behaviour is unchanged, so D can still progress via the lock.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then f_req=1, f_addr=0x8 for one cycle → f_gnt=1, mem_address=0x8; next cycle f_rvalid=1 and f_rdata=memory word 2, f_err=0.
- f_req and d_req both held high with addresses 0x0 and 0x4 for 4 cycles → grants F,D,F,D; responses return word 0 and word 1 alternately, one cycle after each grant.
- d_req=1, d_lock=1, f_req=1 held for 20 cycles with LOCK_MAX=16 → 16 D grants, 1 F grant, then D resumes; drop d_lock → RR alternation restarts.
- Errors: f_addr=0x6 → f_err=1, f_rdata=0. d_addr=0x204 with DEPTH=129 → d_err=1. d_addr=0x200 → d_err=0.
- Assert reset during a LOCK burst with a grant in flight → no rvalid the following cycle; after reset, a tie grants F first.
- With IMEM_ARB_FIXED_PRIO_EN defined and both requesting in RR → F granted every cycle; D is granted only when f_req=0.

Source files
------------

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares the single combinational instruction-memory read port between the
// fetch stage (port F) and a debug/loader read port (port D). At most one
// request is granted per cycle. The granted address is driven to the memory,
// and the word it returns is handed back one cycle later through a registered
// response on the port that was granted.
//
// Arbitration:
//   RR   - a lone request is granted. When both ports request, the port that
//          was not granted last wins.
//   LOCK - entered on a D grant while d_lock is held. D has priority, but after
//          LOCK_MAX D grants a waiting F request is granted once. The lock is
//          left as soon as d_lock drops.
//
// Errors: a misaligned address, or a word index >= DEPTH, returns rdata = 0
// (NOP) with err = 1. rvalid is still asserted.
//
// Build option:
//   IMEM_ARB_FIXED_PRIO_EN - when defined, RR-state ties always go to F and
//                            the last-grant pointer no longer steers them.
//                            LOCK behaviour is unchanged.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   f_req, f_addr     - fetch request and byte address
//   f_gnt             - fetch accepted this cycle (combinational)
//   f_rvalid, f_rdata, f_err - fetch response, one cycle after the grant
//   d_req, d_addr     - debug request and byte address
//   d_lock            - debug asks for a burst lock
//   d_gnt             - debug accepted this cycle (combinational)
//   d_rvalid, d_rdata, d_err - debug response, one cycle after the grant
//   mem_address       - byte address driven to instruction memory
//   mem_instruction   - combinational read data from instruction memory
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int unsigned DEPTH    = 129,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic [31:0] mem_address,
    input  logic [31:0] mem_instruction
);

    typedef enum logic {
        ST_RR   = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam int unsigned     CNT_W       = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [29:0]      DEPTH_WORDS = 30'(DEPTH);

    state_t           state;
    logic [CNT_W-1:0] lock_cnt;
    logic             last_d;      // 1 when the most recent grant went to D
    logic             quota_hit;   // D has used up its locked burst
    logic             sel_err;     // error status of the address being granted

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_WORDS);
    endfunction

    assign quota_hit = (lock_cnt == CNT_MAX);

    // -------------------------------------------------------------------------
    // Grant decision. Reset suppresses every grant, so a request presented
    // together with reset is simply not accepted.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (state == ST_LOCK) begin
                // D keeps priority until its quota is used; F also gets the
                // port on any cycle D is idle.
                if (f_req && (!d_req || quota_hit)) begin
                    f_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end
            end else if (f_req && d_req) begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
                f_gnt = 1'b1;
`else
                f_gnt = last_d;
                d_gnt = !last_d;
`endif
            end else begin
                f_gnt = f_req;
                d_gnt = d_req;
            end
        end
    end

    // With no D grant the fetch address passes straight through, so the
    // fetch path stays transparent even on idle cycles.
    assign mem_address = d_gnt ? d_addr : f_addr;
    assign sel_err     = addr_err(mem_address);

    // -------------------------------------------------------------------------
    // Arbitration state and registered responses.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the response data registers are cleared too, so a read of
            // rdata straight after reset returns the defined NOP encoding.
            state    <= ST_RR;
            lock_cnt <= '0;
            last_d   <= 1'b1;      // F wins the first tie after reset
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_err    <= 1'b0;
            d_err    <= 1'b0;
            f_rdata  <= 32'h0;
            d_rdata  <= 32'h0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            f_rvalid <= f_gnt;
            d_rvalid <= d_gnt;
            f_err    <= f_gnt & sel_err;
            d_err    <= d_gnt & sel_err;
            if (f_gnt) begin
                f_rdata <= sel_err ? 32'h0 : mem_instruction;
            end
            if (d_gnt) begin
                d_rdata <= sel_err ? 32'h0 : mem_instruction;
            end

            if (f_gnt) begin
                last_d <= 1'b0;
            end else if (d_gnt) begin
                last_d <= 1'b1;
            end

            unique case (state)
                ST_RR: begin
                    // The D grant that opens the lock is the first of the
                    // burst, so the counter starts at one.
                    if (d_gnt && d_lock) begin
                        state    <= ST_LOCK;
                        lock_cnt <= CNT_ONE;
                    end
                end
                ST_LOCK: begin
                    if (!d_lock) begin
                        state    <= ST_RR;
                        lock_cnt <= '0;
                    end else if (d_gnt) begin
                        // Saturate: with F idle D may keep going past the quota.
                        if (!quota_hit) begin
                            lock_cnt <= lock_cnt + CNT_ONE;
                        end
                    end else if (f_gnt && quota_hit) begin
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_RR;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

    localparam int unsigned DEPTH    = 129;
    localparam int unsigned LOCK_MAX = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_lock;
    logic [31:0] f_addr, d_addr;
    logic        f_gnt, d_gnt;
    logic        f_rvalid, d_rvalid, f_err, d_err;
    logic [31:0] f_rdata, d_rdata;
    logic [31:0] mem_address, mem_instruction;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] mem [DEPTH];

    imem_arbiter #(.DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_addr(d_addr), .d_lock(d_lock), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_instruction(mem_instruction)
    );

    always #5 clk = ~clk;

    // Instruction memory: combinational read, garbage outside the array.
    always_comb begin
        mem_instruction = 32'hBAD0_BAD0;
        if ((mem_address / 4) < DEPTH) mem_instruction = mem[mem_address / 4];
    end

    // One cycle of observed vs expected behaviour.
    typedef struct packed {
        logic        fg;
        logic        dg;
        logic [31:0] ma;
        logic        frv;
        logic [31:0] frd;
        logic        fer;
        logic        drv;
        logic [31:0] drd;
        logic        der;
    } cyc_t;

    // Reference model: whether D currently holds a lock, how many D grants
    // the current lock run has used, and who was served last.
    bit m_locked = 1'b0;
    int m_streak = 0;
    bit m_last_d = 1'b1;

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    task automatic model_grant(output bit gf, output bit gd);
        gf = 1'b0;
        gd = 1'b0;
        if (reset === 1'b1) return;
        if (m_locked) begin
            gf = (f_req === 1'b1) && (d_req !== 1'b1 || m_streak >= LOCK_MAX);
            gd = (d_req === 1'b1) && !gf;
        end else if (f_req === 1'b1 && d_req === 1'b1) begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
            gf = 1'b1;
`else
            gf = m_last_d;
`endif
            gd = !gf;
        end else begin
            gf = (f_req === 1'b1);
            gd = (d_req === 1'b1);
        end
    endtask

    task automatic model_update(input bit gf, input bit gd);
        if (reset === 1'b1) begin
            m_locked = 1'b0;
            m_streak = 0;
            m_last_d = 1'b1;
            return;
        end
        if (gd) m_last_d = 1'b1;
        else if (gf) m_last_d = 1'b0;
        if (!m_locked) begin
            if (gd && d_lock === 1'b1) begin
                m_locked = 1'b1;
                m_streak = 1;
            end
        end else if (d_lock !== 1'b1) begin
            m_locked = 1'b0;
            m_streak = 0;
        end else if (gd) begin
            if (m_streak < LOCK_MAX) m_streak++;
        end else if (gf && m_streak >= LOCK_MAX) begin
            m_streak = 0;
        end
    endtask

    // Runs one clock cycle with the inputs already driven; returns what the
    // DUT did and what the model expects. rdata is don't-care without rvalid.
    task automatic do_cycle(output cyc_t obs, output cyc_t exp);
        bit gf, gd, er;
        logic [31:0] a, word;
        #1;
        model_grant(gf, gd);
        a  = gd ? d_addr : f_addr;
        er = addr_bad(a);
        word = er ? 32'h0 : mem[a / 4];
        obs = '0;
        exp = '0;
        exp.fg = gf;  exp.dg = gd;  exp.ma = a;
        obs.fg = f_gnt; obs.dg = d_gnt; obs.ma = mem_address;
        @(posedge clk);
        #1;
        model_update(gf, gd);
        exp.frv = gf; exp.fer = gf && er; exp.frd = gf ? word : 32'h0;
        exp.drv = gd; exp.der = gd && er; exp.drd = gd ? word : 32'h0;
        obs.frv = f_rvalid; obs.fer = f_err; obs.frd = f_rvalid ? f_rdata : 32'h0;
        obs.drv = d_rvalid; obs.der = d_err; obs.drd = d_rvalid ? d_rdata : 32'h0;
    endtask

    task automatic idle_inputs();
        f_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        f_addr = 32'h0; d_addr = 32'h0;
    endtask

    task automatic apply_reset();
        cyc_t o, e;
        idle_inputs();
        reset = 1'b1;
        do_cycle(o, e);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cyc_t o, e;
        idle_inputs();
        reset = 1'b1;
        do_cycle(o, e);
        compared++;
        if (o !== e) begin
            mismatched++;
            $display("FAIL reset_idle: got %h expected %h", o, e);
        end
        compared++;
        if (f_rdata !== 32'h0 || d_rdata !== 32'h0 || f_err !== 1'b0 || d_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_regs: got f_rdata=%h d_rdata=%h f_err=%b d_err=%b expected zeros",
                     f_rdata, d_rdata, f_err, d_err);
        end
        // Requests presented together with reset must not be granted.
        f_req = 1'b1; d_req = 1'b1; d_lock = 1'b1; f_addr = 32'h4; d_addr = 32'h8;
        do_cycle(o, e);
        compared++;
        if (o !== e) begin
            mismatched++;
            $display("FAIL reset_with_req: got %h expected %h", o, e);
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_fetch();
        cyc_t o, e;
        apply_reset();
        f_req = 1'b1; f_addr = 32'h8;
        do_cycle(o, e);
        compared++;
        if (o !== e || o.frd !== mem[2]) begin
            mismatched++;
            $display("FAIL single_fetch: got %h expected %h (word2=%h)", o, e, mem[2]);
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        cyc_t o, e;
        apply_reset();
        f_req = 1'b1; d_req = 1'b1; f_addr = 32'h0; d_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            do_cycle(o, e);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL round_robin[%0d]: got %h expected %h", i, o, e);
            end
        end
        idle_inputs();
    endtask

    task automatic test_lock_burst();
        cyc_t o, e;
        int d_run;
        logic [19:0] fg_seen;
        apply_reset();
        f_req = 1'b1; d_req = 1'b1; d_lock = 1'b1;
        f_addr = 32'h10; d_addr = 32'h20;
        fg_seen = '0;
        d_run = 0;
        for (int i = 0; i < 20; i++) begin
            do_cycle(o, e);
            fg_seen[i] = o.fg;
            if (i >= 1 && i <= 16 && o.dg === 1'b1) d_run++;
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL lock_burst[%0d]: got %h expected %h", i, o, e);
            end
        end
`ifndef IMEM_ARB_FIXED_PRIO_EN
        // Tie after reset goes to F, then 16 locked D grants, one F, D again.
        compared++;
        if (d_run !== 16 || fg_seen !== 20'h20001) begin
            mismatched++;
            $display("FAIL lock_pattern: got d_run=%0d f_grants=%h expected d_run=16 f_grants=20001",
                     d_run, fg_seen);
        end
`endif
        d_lock = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_cycle(o, e);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL lock_release[%0d]: got %h expected %h", i, o, e);
            end
        end
        idle_inputs();
    endtask

    task automatic test_errors();
        cyc_t o, e;
        logic [31:0] f_tab [3];
        logic [31:0] d_tab [4];
        f_tab = '{32'h6, 32'hFFFF_FFFC, 32'h204};
        d_tab = '{32'h204, 32'h200, 32'hFFFF_FFFC, 32'h3};
        apply_reset();
        foreach (f_tab[i]) begin
            idle_inputs();
            f_req = 1'b1; f_addr = f_tab[i];
            do_cycle(o, e);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL f_err_addr %h: got %h expected %h", f_tab[i], o, e);
            end
        end
        foreach (d_tab[i]) begin
            idle_inputs();
            d_req = 1'b1; d_addr = d_tab[i];
            do_cycle(o, e);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL d_err_addr %h: got %h expected %h", d_tab[i], o, e);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        cyc_t o, e;
        apply_reset();
        d_req = 1'b1; d_lock = 1'b1; f_req = 1'b1;
        d_addr = 32'h40; f_addr = 32'h44;
        for (int i = 0; i < 5; i++) do_cycle(o, e);
        reset = 1'b1;
        do_cycle(o, e);
        compared++;
        if (o !== e || o.frv !== 1'b0 || o.drv !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_burst: got %h expected %h", o, e);
        end
        reset = 1'b0; d_lock = 1'b0;
        for (int i = 0; i < 2; i++) begin
            do_cycle(o, e);
            compared++;
            if (o !== e || (i == 0 && o.fg !== 1'b1)) begin
                mismatched++;
                $display("FAIL post_reset_tie[%0d]: got %h expected %h", i, o, e);
            end
        end
        idle_inputs();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return $urandom();
            1:       return (32'(DEPTH) * 4) + ($urandom_range(0, 3) * 4);
            2:       return ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
            default: return $urandom_range(0, DEPTH - 1) * 4;
        endcase
    endfunction

    task automatic test_random();
        cyc_t o, e;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            // A request may change only once the previous one was granted.
            if (f_req !== 1'b1 || o.fg === 1'b1 || i == 0) begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = rand_addr();
            end
            if (d_req !== 1'b1 || o.dg === 1'b1 || i == 0) begin
                d_req  = ($urandom_range(0, 2) != 0);
                d_addr = rand_addr();
            end
            if ($urandom_range(0, 7) == 0) d_lock = ~d_lock;
            reset = ($urandom_range(0, 79) == 0);
            if (reset) begin
                f_req = 1'b0;
                d_req = 1'b0;
            end
            do_cycle(o, e);
            compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL random[%0d]: got %h expected %h", i, o, e);
            end
            if (reset) begin
                reset = 1'b0;
                f_req = 1'b0;
                d_req = 1'b0;
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        foreach (mem[i]) mem[i] = $urandom();
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_lock_burst();
        test_errors();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
